// File: rtl/core_pkg.sv
// Shared control-unit definitions: sequencer states and one-hot exception/interrupt phase codes.
// The HALT_DF state exists only when CORE_DOUBLE_FAULT_EN is defined.
package core_pkg;

    localparam int unsigned CORE_PC_W = 32;
    localparam int unsigned EXC_W     = 4;
    localparam int unsigned INT_W     = 3;

    localparam logic [EXC_W-1:0] EXC_NONE    = 4'b0000;
    localparam logic [EXC_W-1:0] EXC_SAVE_S  = 4'b0001;
    localparam logic [EXC_W-1:0] EXC_SAVE_A  = 4'b0010;
    localparam logic [EXC_W-1:0] EXC_VEC_S   = 4'b0100;
    localparam logic [EXC_W-1:0] EXC_VEC_A   = 4'b1000;
    localparam logic [EXC_W-1:0] EXC_HALT_DF = 4'b1000;

    localparam logic [INT_W-1:0] INT_NONE = 3'b000;
    localparam logic [INT_W-1:0] INT_P1   = 3'b001;
    localparam logic [INT_W-1:0] INT_P2   = 3'b010;
    localparam logic [INT_W-1:0] INT_VEC  = 3'b100;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_EXC_SAVE_S = 4'd1,
        ST_EXC_SAVE_A = 4'd2,
        ST_EXC_VEC_S  = 4'd3,
        ST_EXC_VEC_A  = 4'd4,
        ST_INT_P1     = 4'd5,
        ST_INT_P2     = 4'd6,
        ST_INT_VEC    = 4'd7
`ifdef CORE_DOUBLE_FAULT_EN
        ,
        ST_HALT_DF    = 4'd8
`endif
    } seq_state_t;

    function automatic logic [EXC_W-1:0] exc_code(input seq_state_t s);
        logic [EXC_W-1:0] c;
        c = EXC_NONE;
        case (s)
            ST_EXC_SAVE_S: c = EXC_SAVE_S;
            ST_EXC_SAVE_A: c = EXC_SAVE_A;
            ST_EXC_VEC_S:  c = EXC_VEC_S;
            ST_EXC_VEC_A:  c = EXC_VEC_A;
`ifdef CORE_DOUBLE_FAULT_EN
            ST_HALT_DF:    c = EXC_HALT_DF;
`endif
            default:       c = EXC_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [INT_W-1:0] int_code(input seq_state_t s);
        logic [INT_W-1:0] c;
        c = INT_NONE;
        case (s)
            ST_INT_P1:  c = INT_P1;
            ST_INT_P2:  c = INT_P2;
            ST_INT_VEC: c = INT_VEC;
            default:    c = INT_NONE;
        endcase
        return c;
    endfunction

    // Successor of an exception phase when no new exception interferes.
    function automatic seq_state_t exc_next(input seq_state_t s);
        seq_state_t n;
        n = ST_IDLE;
        case (s)
            ST_EXC_SAVE_S: n = ST_EXC_VEC_S;
            ST_EXC_SAVE_A: n = ST_EXC_VEC_A;
            default:       n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/int_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
// STAGES must be at least 2; rise_c is a one-cycle pulse derived from flop outputs only.
module int_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_exc_sequencer.sv
// Exception/interrupt entry sequencer feeding one-hot phase codes to the control unit.
// Optional double-fault halt is enabled by defining CORE_DOUBLE_FAULT_EN.
module int_exc_sequencer
    import core_pkg::*;
#(
    parameter int unsigned PC_W        = CORE_PC_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_int,
    input  logic             exc_empty_stack,
    input  logic             exc_bad_addr,
    input  logic [PC_W-1:0]  mem_pc,
    input  logic             stall,
    output logic [EXC_W-1:0] exceptions,
    output logic [INT_W-1:0] interrupts,
    output logic [PC_W-1:0]  epc,
    output logic             busy,
    output logic             int_pending
`ifdef CORE_DOUBLE_FAULT_EN
    ,
    output logic             double_fault
`endif
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       rise_c;
    logic       pend_s_q;
    logic       pend_a_q;
    logic       pend_s_d;
    logic       pend_a_d;
    logic       int_pend_d;
    logic       capture_epc;
    logic       eff_s;
    logic       eff_a;
`ifdef CORE_DOUBLE_FAULT_EN
    logic       df_set;
`endif

    int_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (ext_int),
        .rise_c   (rise_c)
    );

    // An exception is live if pulsed now or remembered from a stall / INT_VEC.
    assign eff_s = exc_empty_stack | pend_s_q;
    assign eff_a = exc_bad_addr | pend_a_q;

    always_comb begin
        state_d     = state_q;
        pend_s_d    = pend_s_q | exc_empty_stack;
        pend_a_d    = pend_a_q | exc_bad_addr;
        int_pend_d  = int_pending;
        capture_epc = 1'b0;
`ifdef CORE_DOUBLE_FAULT_EN
        df_set      = 1'b0;
`endif
        if (!stall) begin
            pend_s_d = 1'b0;
            pend_a_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (eff_s) begin
                        state_d     = ST_EXC_SAVE_S;
                        capture_epc = 1'b1;
                    end else if (eff_a) begin
                        state_d     = ST_EXC_SAVE_A;
                        capture_epc = 1'b1;
                    end else if (int_pending) begin
                        state_d    = ST_INT_P1;
                        int_pend_d = 1'b0;
                    end
                end
                ST_INT_P1, ST_INT_P2: begin
                    if (eff_s) begin
                        state_d     = ST_EXC_SAVE_S;
                        capture_epc = 1'b1;
                        int_pend_d  = 1'b1;
                    end else if (eff_a) begin
                        state_d     = ST_EXC_SAVE_A;
                        capture_epc = 1'b1;
                        int_pend_d  = 1'b1;
                    end else begin
                        state_d = (state_q == ST_INT_P1) ? ST_INT_P2 : ST_INT_VEC;
                    end
                end
                ST_INT_VEC: begin
                    state_d  = ST_IDLE;
                    pend_s_d = eff_s;
                    pend_a_d = eff_a;
                end
                ST_EXC_SAVE_S, ST_EXC_SAVE_A, ST_EXC_VEC_S, ST_EXC_VEC_A: begin
                    state_d = exc_next(state_q);
`ifdef CORE_DOUBLE_FAULT_EN
                    if (eff_s || eff_a) begin
                        state_d = ST_HALT_DF;
                        df_set  = 1'b1;
                    end
`endif
                end
`ifdef CORE_DOUBLE_FAULT_EN
                ST_HALT_DF: state_d = ST_HALT_DF;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
        // A fresh pin edge always wins over the clear on interrupt entry.
        if (rise_c) begin
            int_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            exceptions  <= EXC_NONE;
            interrupts  <= INT_NONE;
            busy        <= 1'b0;
            int_pending <= 1'b0;
            pend_s_q    <= 1'b0;
            pend_a_q    <= 1'b0;
            epc         <= '0;
`ifdef CORE_DOUBLE_FAULT_EN
            double_fault <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            exceptions  <= exc_code(state_d);
            interrupts  <= int_code(state_d);
            busy        <= (state_d != ST_IDLE);
            int_pending <= int_pend_d;
            pend_s_q    <= pend_s_d;
            pend_a_q    <= pend_a_d;
            if (capture_epc) begin
                epc <= mem_pc;
            end
`ifdef CORE_DOUBLE_FAULT_EN
            double_fault <= double_fault | df_set;
`endif
        end
    end

endmodule

// File: tb/tb_int_exc_sequencer.sv
// Bench for int_exc_sequencer: directed scenarios plus random traffic against a phase-script model.
// Works with or without CORE_DOUBLE_FAULT_EN defined.
module tb_int_exc_sequencer;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ext_int = 1'b0;
    logic        exc_empty_stack = 1'b0;
    logic        exc_bad_addr = 1'b0;
    logic [31:0] mem_pc = 32'h0;
    logic        stall = 1'b0;
    logic [3:0]  exceptions;
    logic [2:0]  interrupts;
    logic [31:0] epc;
    logic        busy;
    logic        int_pending;
`ifdef CORE_DOUBLE_FAULT_EN
    logic        double_fault;
`endif

    int checks = 0;
    int failures = 0;

    int_exc_sequencer #(.PC_W(32), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .reset           (reset),
        .ext_int         (ext_int),
        .exc_empty_stack (exc_empty_stack),
        .exc_bad_addr    (exc_bad_addr),
        .mem_pc          (mem_pc),
        .stall           (stall),
        .exceptions      (exceptions),
        .interrupts      (interrupts),
        .epc             (epc),
        .busy            (busy),
        .int_pending     (int_pending)
`ifdef CORE_DOUBLE_FAULT_EN
        ,
        .double_fault    (double_fault)
`endif
    );

    always #5 clk = ~clk;

    // Model: current phase code {exc,int} plus a script of remaining phases.
    logic [6:0]  m_cur;
    logic [6:0]  m_rem[$];
    logic        m_ip, m_ps, m_pa, m_df;
    logic [31:0] m_epc;
    logic [15:0] m_hist;

    function automatic void m_start(input logic is_s);
        m_cur = is_s ? 7'b0001_000 : 7'b0010_000;
        m_rem.delete();
        m_rem.push_back(is_s ? 7'b0100_000 : 7'b1000_000);
        m_epc = mem_pc;
    endfunction

    function automatic void m_advance();
        if (m_rem.size() > 0) m_cur = m_rem.pop_front();
        else m_cur = 7'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic rise, s, a;
        if (!reset) begin
            m_cur = 7'b0; m_rem.delete(); m_ip = 0; m_ps = 0; m_pa = 0; m_df = 0;
            m_epc = 32'h0; m_hist = 16'h0;
        end else begin
            rise = m_hist[SYNC-1] & ~m_hist[SYNC];
            m_hist = {m_hist[14:0], ext_int};
            if (stall) begin
                m_ps = m_ps | exc_empty_stack;
                m_pa = m_pa | exc_bad_addr;
            end else begin
                s = exc_empty_stack | m_ps;
                a = exc_bad_addr | m_pa;
                m_ps = 0; m_pa = 0;
                if (m_df) begin
                    m_df = 1'b1;
                end else if (m_cur == 7'b0) begin
                    if (s) m_start(1'b1);
                    else if (a) m_start(1'b0);
                    else if (m_ip) begin
                        m_cur = 7'b0000_001; m_rem.delete();
                        m_rem.push_back(7'b0000_010); m_rem.push_back(7'b0000_100);
                        m_ip = 0;
                    end
                end else if (m_cur == 7'b0000_001 || m_cur == 7'b0000_010) begin
                    if (s || a) begin m_ip = 1; m_start(s); end
                    else m_advance();
                end else if (m_cur == 7'b0000_100) begin
                    m_advance(); m_ps = s; m_pa = a;
                end else begin
`ifdef CORE_DOUBLE_FAULT_EN
                    if (s || a) begin m_df = 1; m_cur = 7'b1000_000; m_rem.delete(); end
                    else m_advance();
`else
                    m_advance();
`endif
                end
            end
            if (rise) m_ip = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; ext_int = 0; exc_empty_stack = 0; exc_bad_addr = 0; stall = 0; mem_pc = 0;
        cyc(); cyc();
        reset = 1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        ext_int = 1;
        repeat (5) cyc();
        checks++; if (interrupts !== 3'b010) begin failures++; $display("FAIL reset_pre_p2 interrupts=%b exp=010", interrupts); end
        #1 reset = 0; ext_int = 0;
        #1;
        checks++; if (exceptions !== 4'b0) begin failures++; $display("FAIL reset_exc exceptions=%b exp=0000", exceptions); end
        checks++; if (interrupts !== 3'b0) begin failures++; $display("FAIL reset_int interrupts=%b exp=000", interrupts); end
        checks++; if (busy !== 1'b0 || int_pending !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b int_pending=%b exp=0/0", busy, int_pending); end
        checks++; if (epc !== 32'h0) begin failures++; $display("FAIL reset_epc epc=%h exp=0", epc); end
        @(negedge clk); cyc();
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++; if (busy !== 1'b0 || int_pending !== 1'b0) begin failures++; $display("FAIL reset_quiet cyc=%0d busy=%b int_pending=%b exp=0/0", i, busy, int_pending); end
        end
    endtask

    task automatic test_interrupt();
        int busy_cnt = 0;
        logic [2:0] exp_i;
        do_reset();
        ext_int = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            exp_i = (i == 3) ? 3'b001 : (i == 4) ? 3'b010 : (i == 5) ? 3'b100 : 3'b000;
            if (busy) busy_cnt++;
            checks++; if (interrupts !== exp_i) begin failures++; $display("FAIL int_seq cyc=%0d interrupts=%b exp=%b", i, interrupts, exp_i); end
            checks++; if (int_pending !== (i == 2)) begin failures++; $display("FAIL int_pending cyc=%0d got=%b exp=%b", i, int_pending, (i == 2)); end
        end
        checks++; if (busy_cnt != 3) begin failures++; $display("FAIL int_busy_len got=%0d exp=3", busy_cnt); end
        ext_int = 0;
        repeat (3) cyc();
    endtask

    task automatic test_exception();
        do_reset();
        exc_bad_addr = 1; mem_pc = 32'h0000_0123;
        cyc();
        exc_bad_addr = 0; mem_pc = 32'hdead_beef;
        checks++; if (exceptions !== 4'b0010) begin failures++; $display("FAIL exc_save_a exceptions=%b exp=0010", exceptions); end
        checks++; if (epc !== 32'h123) begin failures++; $display("FAIL exc_epc epc=%h exp=00000123", epc); end
        cyc();
        checks++; if (exceptions !== 4'b1000) begin failures++; $display("FAIL exc_vec_a exceptions=%b exp=1000", exceptions); end
        cyc();
        checks++; if (exceptions !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL exc_done exceptions=%b busy=%b exp=0000/0", exceptions, busy); end
        checks++; if (epc !== 32'h123) begin failures++; $display("FAIL exc_epc_hold epc=%h exp=00000123", epc); end
    endtask

    task automatic run_exc_then_int(input string name);
        logic [3:0] exp_e [0:6];
        logic [2:0] exp_i [0:6];
        exp_e = '{4'b0001, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        exp_i = '{3'b0, 3'b0, 3'b0, 3'b001, 3'b010, 3'b100, 3'b0};
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i == 0) begin
                exc_empty_stack = 0; exc_bad_addr = 0;
                checks++; if (int_pending !== 1'b1) begin failures++; $display("FAIL %s_keep_pending got=%b exp=1", name, int_pending); end
            end
            checks++; if (exceptions !== exp_e[i] || interrupts !== exp_i[i]) begin failures++; $display("FAIL %s_seq cyc=%0d exc=%b int=%b exp=%b/%b", name, i, exceptions, interrupts, exp_e[i], exp_i[i]); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        ext_int = 1;
        repeat (3) cyc();
        checks++; if (int_pending !== 1'b1) begin failures++; $display("FAIL prio_pending got=%b exp=1", int_pending); end
        exc_empty_stack = 1; exc_bad_addr = 1; mem_pc = 32'h40;
        run_exc_then_int("prio");
        checks++; if (epc !== 32'h40) begin failures++; $display("FAIL prio_epc epc=%h exp=00000040", epc); end
        ext_int = 0;
        repeat (3) cyc();
    endtask

    task automatic test_abort();
        do_reset();
        ext_int = 1;
        repeat (4) cyc();
        checks++; if (interrupts !== 3'b001) begin failures++; $display("FAIL abort_p1 interrupts=%b exp=001", interrupts); end
        exc_empty_stack = 1; mem_pc = 32'h200;
        run_exc_then_int("abort");
        checks++; if (epc !== 32'h200) begin failures++; $display("FAIL abort_epc epc=%h exp=00000200", epc); end
        ext_int = 0;
        repeat (3) cyc();
    endtask

    task automatic test_stall();
        do_reset();
        exc_empty_stack = 1;
        cyc();
        exc_empty_stack = 0;
        checks++; if (exceptions !== 4'b0001) begin failures++; $display("FAIL stall_save exceptions=%b exp=0001", exceptions); end
        cyc();
        checks++; if (exceptions !== 4'b0100) begin failures++; $display("FAIL stall_vec exceptions=%b exp=0100", exceptions); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (exceptions !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL stall_hold cyc=%0d exceptions=%b busy=%b exp=0100/1", i, exceptions, busy); end
        end
        stall = 0;
        cyc();
        checks++; if (exceptions !== 4'b0000) begin failures++; $display("FAIL stall_release exceptions=%b exp=0000", exceptions); end
    endtask

    task automatic test_double_fault();
        do_reset();
        exc_empty_stack = 1; mem_pc = 32'h300;
        cyc();
        exc_empty_stack = 0; exc_bad_addr = 1; mem_pc = 32'h304;
        checks++; if (exceptions !== 4'b0001) begin failures++; $display("FAIL df_save exceptions=%b exp=0001", exceptions); end
        cyc();
        exc_bad_addr = 0;
`ifdef CORE_DOUBLE_FAULT_EN
        for (int i = 0; i < 5; i++) begin
            checks++; if (exceptions !== 4'b1000 || interrupts !== 3'b0 || double_fault !== 1'b1) begin failures++; $display("FAIL df_halt cyc=%0d exc=%b int=%b df=%b exp=1000/000/1", i, exceptions, interrupts, double_fault); end
            cyc();
        end
        do_reset();
        checks++; if (double_fault !== 1'b0 || exceptions !== 4'b0) begin failures++; $display("FAIL df_clear df=%b exc=%b exp=0/0000", double_fault, exceptions); end
`else
        checks++; if (exceptions !== 4'b0100) begin failures++; $display("FAIL nodf_vec exceptions=%b exp=0100", exceptions); end
        cyc();
        checks++; if (exceptions !== 4'b0000) begin failures++; $display("FAIL nodf_done exceptions=%b exp=0000", exceptions); end
        checks++; if (epc !== 32'h300) begin failures++; $display("FAIL nodf_epc epc=%h exp=00000300", epc); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cyc();
            checks++; if (exceptions !== m_cur[6:3] || interrupts !== m_cur[2:0]) begin failures++; $display("FAIL rnd_codes n=%0d exc=%b int=%b exp=%b/%b", n, exceptions, interrupts, m_cur[6:3], m_cur[2:0]); end
            checks++; if (busy !== (m_cur != 7'b0)) begin failures++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, (m_cur != 7'b0)); end
            checks++; if (int_pending !== m_ip) begin failures++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, int_pending, m_ip); end
            checks++; if (epc !== m_epc) begin failures++; $display("FAIL rnd_epc n=%0d got=%h exp=%h", n, epc, m_epc); end
            checks++; if (exceptions != 4'b0 && interrupts != 3'b0) begin failures++; $display("FAIL rnd_exclusive n=%0d exc=%b int=%b exp=one zero", n, exceptions, interrupts); end
`ifdef CORE_DOUBLE_FAULT_EN
            checks++; if (double_fault !== m_df) begin failures++; $display("FAIL rnd_df n=%0d got=%b exp=%b", n, double_fault, m_df); end
`endif
            if ($urandom_range(0, 149) == 0) begin
                reset = 0;
                cyc();
                reset = 1;
            end
            if ($urandom_range(0, 19) == 0) ext_int = ~ext_int;
            exc_empty_stack = ($urandom_range(0, 11) == 0);
            exc_bad_addr = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 5) == 0);
            mem_pc = $urandom;
        end
        stall = 0; exc_empty_stack = 0; exc_bad_addr = 0;
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_exception();
        test_priority();
        test_abort();
        test_stall();
        test_double_fault();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
